// File: rtl/fetch_unit.sv
// F stage: owns the PC, issues single-outstanding word fetches over a req/ack imem handshake,
// and buffers returned words in a 2-entry queue whose head feeds IF/ID (MIPS delay-slot redirects).
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        fetch_clk_F_i,
    input  logic        fetch_rst_n_F_i,
    input  logic        fetch_stall_F_i,
    input  logic        fetch_redir_F_i,
    input  logic [31:0] fetch_redir_pc_F_i,
    output logic        fetch_imem_req_F_o,
    output logic [31:0] fetch_imem_addr_F_o,
    input  logic        fetch_imem_ack_F_i,
    input  logic [31:0] fetch_imem_rdata_F_i,
    output logic [31:0] fetch_instr_F_o,
    output logic [31:0] fetch_pc_F_o,
    output logic [31:0] fetch_pc4_F_o,
    output logic        fetch_valid_F_o
);

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        DS_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;

    logic req;
    logic pop;
    logic ack_ok;
    logic push;
    logic flush;

    always_comb begin
        pop = (count_q != 2'd0) && !fetch_stall_F_i;
        unique case (state_q)
            FETCH:   req = (count_q != 2'd2) || pop;
            default: req = 1'b1;
        endcase
        ack_ok = req && fetch_imem_ack_F_i;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (fetch_redir_F_i) begin
                    pc_d = fetch_redir_pc_F_i;
                    if (count_q != 2'd0) begin
                        // Head goes to D as the delay slot; the second entry and any
                        // in-flight word are wrong-path.
                        flush = 1'b1;
                        if (ack_ok) req_addr_d = fetch_redir_pc_F_i;
                        else        state_d    = DRAIN;
                    end else if (ack_ok) begin
                        push       = 1'b1;
                        req_addr_d = fetch_redir_pc_F_i;
                    end else begin
                        state_d = DS_WAIT;
                    end
                end else if (ack_ok) begin
                    push       = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    req_addr_d = pc_q + 32'd4;
                end
            end
            DRAIN: begin
                if (ack_ok) begin
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
            DS_WAIT: begin
                if (ack_ok) begin
                    push       = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b01: begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    count_d      = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_instr_d = fetch_imem_rdata_F_i;
                        head_pc_d    = req_addr_q;
                    end else begin
                        tail_instr_d = fetch_imem_rdata_F_i;
                        tail_pc_d    = req_addr_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_instr_d = fetch_imem_rdata_F_i;
                        head_pc_d    = req_addr_q;
                    end else begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = fetch_imem_rdata_F_i;
                        tail_pc_d    = req_addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge fetch_clk_F_i) begin
        if (!fetch_rst_n_F_i) begin
            state_q      <= FETCH;
            pc_q         <= PC_RESET;
            req_addr_q   <= PC_RESET;
            count_q      <= '0;
            head_instr_q <= '0;
            head_pc_q    <= PC_RESET;
            tail_instr_q <= '0;
            tail_pc_q    <= PC_RESET;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    always_comb begin
        fetch_valid_F_o     = fetch_rst_n_F_i && (count_q != 2'd0);
        fetch_imem_req_F_o  = fetch_rst_n_F_i && req;
        fetch_imem_addr_F_o = req_addr_q;
        fetch_instr_F_o     = fetch_valid_F_o ? head_instr_q : '0;
        fetch_pc_F_o        = fetch_valid_F_o ? head_pc_q : PC_RESET;
        fetch_pc4_F_o       = fetch_pc_F_o + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: driver issues stall/redirect/reset and models a variable-latency
// imem; expected program-order (pc, instr) stream is queued and checked by a separate monitor.
module tb_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;

    fetch_unit #(.PC_RESET(PC_RESET)) dut (
        .fetch_clk_F_i        (clk),
        .fetch_rst_n_F_i      (rst_n),
        .fetch_stall_F_i      (stall),
        .fetch_redir_F_i      (redir),
        .fetch_redir_pc_F_i   (redir_pc),
        .fetch_imem_req_F_o   (req),
        .fetch_imem_addr_F_o  (addr),
        .fetch_imem_ack_F_i   (ack),
        .fetch_imem_rdata_F_i (rdata),
        .fetch_instr_F_o      (instr),
        .fetch_pc_F_o         (pc),
        .fetch_pc4_F_o        (pc4),
        .fetch_valid_F_o      (valid)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference: upcoming instruction addresses in program order, as D should see them.
    logic [31:0] exp_q[$];
    logic [31:0] fill_pc;
    int unsigned consumed_total = 0;
    int unsigned since_redir    = 2;
    bit          last_consumed  = 0;

    bit          mem_busy = 0;
    int unsigned mem_wait = 0;
    int unsigned min_lat  = 0;
    int unsigned max_lat  = 0;
    int unsigned stall_pct = 0;
    int unsigned redir_pct = 0;
    int unsigned rst_pct   = 0;
    int unsigned base;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back(fill_pc);
            fill_pc += 32'd4;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        fill_pc     = PC_RESET;
        since_redir = 2;
        top_up();
    endfunction

    // Whatever D consumes next is the delay slot; everything after it follows the target.
    function automatic void model_redirect(input logic [31:0] target);
        logic [31:0] ds;
        ds = exp_q[0];
        exp_q.delete();
        exp_q.push_back(ds);
        fill_pc = target;
        top_up();
    endfunction

    task automatic drive_cycle(input bit do_rst, input bit force_stall);
        @(negedge clk);
        rst_n = !do_rst;
        redir = 1'b0;
        stall = 1'b0;
        if (do_rst) begin
            model_reset();
        end else if (force_stall) begin
            stall = 1'b1;
        end else if (last_consumed && since_redir >= 2 && $urandom_range(99) < redir_pct) begin
            redir       = 1'b1;
            redir_pc    = PC_RESET + 32'($urandom_range(255)) * 32'd4;
            since_redir = 0;
            model_redirect(redir_pc);
        end else begin
            stall = ($urandom_range(99) < stall_pct);
        end
        top_up();
        #1;
        ack = 1'b0;
        if (!rst_n) begin
            mem_busy = 0;
        end else if (req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_wait = $urandom_range(max_lat, min_lat);
            end
            if (mem_wait == 0) begin
                ack      = 1'b1;
                rdata    = addr ^ KEY;
                mem_busy = 0;
            end else begin
                mem_wait--;
            end
        end
        #2;
    endtask

    // Monitor
    initial begin
        bit          first_after_rst = 0;
        bit          hold_pend = 0;
        logic [31:0] hold_addr = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check32("rst_req", {31'd0, req}, 32'd0);
                check32("rst_valid", {31'd0, valid}, 32'd0);
                check32("rst_instr", instr, 32'd0);
                check32("rst_pc", pc, PC_RESET);
                check32("rst_pc4", pc4, PC_RESET + 32'd4);
                first_after_rst = 1;
                hold_pend       = 0;
                last_consumed   = 0;
            end else begin
                if (first_after_rst) begin
                    check32("post_rst_req", {31'd0, req}, 32'd1);
                    check32("post_rst_addr", addr, PC_RESET);
                    first_after_rst = 0;
                end
                if (hold_pend) begin
                    check32("req_held", {31'd0, req}, 32'd1);
                    check32("addr_held", addr, hold_addr);
                end
                hold_pend = req && !ack;
                hold_addr = addr;
                check32("pc4", pc4, pc + 32'd4);
                if (!valid) begin
                    check32("bubble_instr", instr, 32'd0);
                    check32("bubble_pc", pc, PC_RESET);
                end
                if (valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        check32("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check32("d_pc", pc, e);
                        check32("d_instr", instr, e ^ KEY);
                    end
                    consumed_total++;
                    since_redir++;
                    last_consumed = 1;
                end else begin
                    last_consumed = 0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = '0; ack = 1'b0; rdata = '0;
        model_reset();
        drive_cycle(1, 0);
        drive_cycle(1, 0);

        // 1-cycle memory, no stalls: one instruction per cycle from the second cycle on.
        base = consumed_total;
        repeat (20) drive_cycle(0, 0);
        check32("throughput", consumed_total - base, 32'd19);

        // Stall fills the queue; request must stop once both entries are occupied.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 1);
            if (i >= 1) check32("full_req", {31'd0, req}, 32'd0);
        end
        repeat (10) drive_cycle(0, 0);

        stall_pct = 25;
        redir_pct = 20;
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin min_lat = 0; max_lat = 0; end
                1: begin min_lat = 3; max_lat = 3; end
                2: begin min_lat = 0; max_lat = 3; end
                default: begin min_lat = 1; max_lat = 2; end
            endcase
            repeat (600) drive_cycle(0, 0);
        end

        min_lat = 0; max_lat = 3; rst_pct = 3;
        repeat (1000) drive_cycle($urandom_range(99) < rst_pct, 0);
        rst_pct = 0;
        repeat (20) drive_cycle(0, 0);

        n_checks++;
        if (consumed_total >= 500) n_pass++;
        else $display("FAIL progress: got %0d consumed required >= 500", consumed_total);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
